// File: rtl/ahb_pkg.sv
`default_nettype none
// ============================================================================
// Module      : ahb_pkg
// Description : Shared AHB encodings, burst-length helper and arbitration
//               mode constants for the multi-manager arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
package ahb_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        BUSY   = 2'd1,
        NONSEQ = 2'd2,
        SEQ    = 2'd3
    } htrans_t;

    typedef enum logic [2:0] {
        SINGLE = 3'd0,
        INCR   = 3'd1,
        WRAP4  = 3'd2,
        INCR4  = 3'd3,
        WRAP8  = 3'd4,
        INCR8  = 3'd5,
        WRAP16 = 3'd6,
        INCR16 = 3'd7
    } hburst_t;

    localparam int ARB_FIXED = 0;
    localparam int ARB_RR    = 1;
    localparam int ARB_WRR   = 2;

    // Fixed-length bursts report their beat count; SINGLE and INCR report 1
    // so they never hold the grant through the beat counter.
    function automatic logic [4:0] burst_beats(input hburst_t b);
        logic [4:0] beats;
        case (b)
            WRAP4,  INCR4:  beats = 5'd4;
            WRAP8,  INCR8:  beats = 5'd8;
            WRAP16, INCR16: beats = 5'd16;
            default:        beats = 5'd1;
        endcase
        return beats;
    endfunction

endpackage : ahb_pkg
`default_nettype wire

// File: rtl/ahb_arbiter_wrr_rr_pick.sv
`default_nettype none
// ============================================================================
// Module      : rr_pick
// Description : Combinational masked round-robin picker; returns the first
//               requester strictly after ptr (wrapping) as a one-hot vector.
// Revision    : 1.0 - initial release
// ============================================================================
module rr_pick #(
    parameter int N     = 4,
    parameter int PTR_W = 2
) (
    input  logic [N-1:0]     req,
    input  logic [PTR_W-1:0] ptr,
    output logic [N-1:0]     gnt
);

    logic [N-1:0] mask;
    logic [N-1:0] masked;
    logic [N-1:0] pool;

    // With ptr = N-1 the mask is empty, which degenerates to fixed priority.
    always_comb begin
        mask = '0;
        for (int i = 0; i < N; i++) begin
            mask[i] = (i > int'(ptr));
        end
        masked = req & mask;
        pool   = (masked != '0) ? masked : req;
        gnt    = pool & (~pool + N'(1));
    end

endmodule : rr_pick
`default_nettype wire

// File: rtl/ahb_arbiter_wrr.sv
`default_nettype none
// ============================================================================
// Module      : ahb_arbiter_wrr
// Description : AHB multi-manager arbiter with fixed, round-robin or weighted
//               round-robin selection, burst/lock hold and data-phase grant.
// Revision    : 1.0 - initial release
// ============================================================================
module ahb_arbiter_wrr
    import ahb_pkg::*;
#(
    parameter int MANAGERS = 4,
    parameter int WEIGHT_W = 4,
    parameter int MODE     = 2
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic [MANAGERS-1:0]          hreq,
    input  logic [MANAGERS-1:0]          hlock,
    input  logic [2*MANAGERS-1:0]        htrans,
    input  logic [3*MANAGERS-1:0]        hburst,
    input  logic [WEIGHT_W*MANAGERS-1:0] weights,
    input  logic                         hready,
    output logic [MANAGERS-1:0]          granted,
    output logic [MANAGERS-1:0]          grantedD,
    output logic                         hmastlock
);

    localparam int IDX_W = $clog2(MANAGERS);

    logic [MANAGERS-1:0] gnt_addr_q, gnt_addr_d;
    logic [MANAGERS-1:0] gnt_data_q, gnt_data_d;
    logic                hmastlock_q, hmastlock_d;
    logic [3:0]          beat_cnt_q, beat_cnt_d;
    logic [WEIGHT_W-1:0] credit_q, credit_d;
    logic [IDX_W-1:0]    ptr_q, ptr_d;

    logic [1:0]          owner_trans;
    logic [2:0]          owner_burst;
    logic                owner_hreq;
    logic                owner_hlock;
    logic [WEIGHT_W-1:0] owner_weight;
    logic [4:0]          owner_beats;
    logic                owner_locked;
    logic                accept_ns;
    logic                accept_seq;
    logic [WEIGHT_W-1:0] credit_inc;
    logic [WEIGHT_W-1:0] weight_eff;
    logic                rearb;
    logic                keep;
    logic                regrant;
    logic [IDX_W-1:0]    pick_ptr;
    logic [MANAGERS-1:0] pick_gnt;
    logic [IDX_W-1:0]    pick_idx;

    // One-hot AND-OR mux of the current owner's sideband signals.
    always_comb begin
        owner_trans  = '0;
        owner_burst  = '0;
        owner_hreq   = 1'b0;
        owner_hlock  = 1'b0;
        owner_weight = '0;
        for (int i = 0; i < MANAGERS; i++) begin
            if (gnt_addr_q[i]) begin
                owner_trans  = owner_trans  | htrans[2*i +: 2];
                owner_burst  = owner_burst  | hburst[3*i +: 3];
                owner_hreq   = owner_hreq   | hreq[i];
                owner_hlock  = owner_hlock  | hlock[i];
                owner_weight = owner_weight | weights[WEIGHT_W*i +: WEIGHT_W];
            end
        end
    end

    always_comb begin
        pick_idx = '0;
        for (int i = 0; i < MANAGERS; i++) begin
            if (pick_gnt[i]) begin
                pick_idx = pick_idx | IDX_W'(i);
            end
        end
    end

    assign pick_ptr = (MODE == ARB_FIXED) ? IDX_W'(MANAGERS - 1) : ptr_q;

    rr_pick #(
        .N     (MANAGERS),
        .PTR_W (IDX_W)
    ) u_rr_pick (
        .req (hreq),
        .ptr (pick_ptr),
        .gnt (pick_gnt)
    );

    always_comb begin
        owner_beats  = burst_beats(hburst_t'(owner_burst));
        owner_locked = owner_hlock & owner_hreq;
        accept_ns    = hready && (owner_trans == NONSEQ);
        accept_seq   = hready && (owner_trans == SEQ);

        beat_cnt_d = beat_cnt_q;
        if (accept_ns) begin
            beat_cnt_d = (owner_beats > 5'd1) ? (owner_beats[3:0] - 4'd1) : 4'd0;
        end else if (accept_seq && (beat_cnt_q != 4'd0)) begin
            beat_cnt_d = beat_cnt_q - 4'd1;
        end

        credit_inc = credit_q;
        if (accept_ns && (credit_q != '1)) begin
            credit_inc = credit_q + WEIGHT_W'(1);
        end
        weight_eff = (owner_weight == '0) ? WEIGHT_W'(1) : owner_weight;

        // The count used here already reflects this edge's beat, so the last
        // beat of a burst is itself the rearbitration point.
        rearb   = hready && (beat_cnt_d == 4'd0) && !owner_locked;
        keep    = (MODE == ARB_WRR) && owner_hreq && (credit_inc < weight_eff);
        regrant = rearb && (hreq != '0) && !keep;

        gnt_addr_d  = regrant ? pick_gnt : gnt_addr_q;
        ptr_d       = regrant ? pick_idx : ptr_q;
        credit_d    = regrant ? '0 : credit_inc;
        gnt_data_d  = hready ? gnt_addr_q : gnt_data_q;
        hmastlock_d = hready ? owner_locked : hmastlock_q;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            gnt_addr_q  <= MANAGERS'(1);
            gnt_data_q  <= MANAGERS'(1);
            hmastlock_q <= 1'b0;
            beat_cnt_q  <= 4'd0;
            credit_q    <= '0;
            ptr_q       <= '0;
        end else begin
            gnt_addr_q  <= gnt_addr_d;
            gnt_data_q  <= gnt_data_d;
            hmastlock_q <= hmastlock_d;
            beat_cnt_q  <= beat_cnt_d;
            credit_q    <= credit_d;
            ptr_q       <= ptr_d;
        end
    end

    assign granted   = gnt_addr_q;
    assign grantedD  = gnt_data_q;
    assign hmastlock = hmastlock_q;

endmodule : ahb_arbiter_wrr
`default_nettype wire

// File: tb/tb_ahb_arbiter_wrr.sv
`default_nettype none
// ============================================================================
// Module      : tb_ahb_arbiter_wrr
// Description : Bench driving one arbiter per mode (0,1,2) with shared stimulus,
//               checked every cycle against an abstract model plus literals.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_ahb_arbiter_wrr;
    import ahb_pkg::*;

    bit          clk;
    logic        reset;
    logic [3:0]  hreq;
    logic [3:0]  hlock;
    logic [7:0]  htrans;
    logic [11:0] hburst;
    logic [15:0] weights;
    logic        hready;

    logic [2:0][3:0] gnt_m;
    logic [2:0][3:0] gntd_m;
    logic [2:0]      ml_m;

    int n_checks = 0;
    int n_fail   = 0;

    for (genvar g = 0; g < 3; g++) begin : g_dut
        ahb_arbiter_wrr #(
            .MANAGERS (4),
            .WEIGHT_W (4),
            .MODE     (g)
        ) u_dut (
            .clk       (clk),
            .reset     (reset),
            .hreq      (hreq),
            .hlock     (hlock),
            .htrans    (htrans),
            .hburst    (hburst),
            .weights   (weights),
            .hready    (hready),
            .granted   (gnt_m[g]),
            .grantedD  (gntd_m[g]),
            .hmastlock (ml_m[g])
        );
    end

    initial forever #5 clk = ~clk;

    // Abstract model: owner held as an integer index per mode.
    int own  [3];
    int ownd [3];
    int cnt  [3];
    int cred [3];
    int ptr  [3];
    bit ml_exp [3];

    function automatic int beats_of(input int b);
        if (b == 2 || b == 3) return 4;
        if (b == 4 || b == 5) return 8;
        if (b == 6 || b == 7) return 16;
        return 1;
    endfunction

    task automatic model_step(input int m);
        int o, t, b, w, win;
        bit lk;
        if (reset) begin
            own[m] = 0; ownd[m] = 0; ml_exp[m] = 0;
            cnt[m] = 0; cred[m] = 0; ptr[m] = 0;
            return;
        end
        if (!hready) return;
        o  = own[m];
        t  = int'(htrans[2*o +: 2]);
        b  = int'(hburst[3*o +: 3]);
        lk = hlock[o] && hreq[o];
        if (t == 2) begin
            cnt[m]  = beats_of(b) - 1;
            cred[m] = cred[m] + 1;
        end else if (t == 3 && cnt[m] > 0) begin
            cnt[m] = cnt[m] - 1;
        end
        win = o;
        if (cnt[m] == 0 && !lk && hreq != 4'b0000) begin
            w = int'(weights[4*o +: 4]);
            if (w == 0) w = 1;
            if (!(m == 2 && hreq[o] && cred[m] < w)) begin
                if (m == 0) begin
                    for (int i = 3; i >= 0; i--) if (hreq[i]) win = i;
                end else begin
                    for (int k = 4; k >= 1; k--) if (hreq[(ptr[m] + k) % 4]) win = (ptr[m] + k) % 4;
                end
                cred[m] = 0;
                ptr[m]  = win;
            end
        end
        ownd[m]   = o;
        ml_exp[m] = lk;
        own[m]    = win;
    endtask

    always @(posedge clk) begin
        for (int m = 0; m < 3; m++) model_step(m);
    end

    always @(negedge clk) begin
        for (int m = 0; m < 3; m++) begin
            n_checks++;
            if (gnt_m[m] !== 4'(1 << own[m]) || gntd_m[m] !== 4'(1 << ownd[m]) || ml_m[m] !== ml_exp[m]) begin
                n_fail++;
                $display("FAIL model_cmp mode%0d t=%0t: granted=%b grantedD=%b hmastlock=%b, required %b %b %b",
                         m, $time, gnt_m[m], gntd_m[m], ml_m[m], 4'(1 << own[m]), 4'(1 << ownd[m]), ml_exp[m]);
            end
        end
    end

    task automatic chk(input string name, input logic [3:0] act, input logic [3:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s t=%0t: got %b, required %b", name, $time, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_xfer(input logic [1:0] t, input logic [2:0] b);
        htrans = {4{t}};
        hburst = {4{b}};
    endtask

    task automatic do_reset();
        reset = 1'b1;
        hreq  = 4'b0000;
        hlock = 4'b0000;
        hready = 1'b1;
        set_xfer(IDLE, SINGLE);
        step();
        reset = 1'b0;
    endtask

    logic [3:0] exp_rr  [4];
    logic [3:0] exp_wrr [6];
    logic [3:0] prev_rr;

    initial begin
        exp_rr  = '{4'b0010, 4'b0100, 4'b1000, 4'b0001};
        exp_wrr = '{4'b0010, 4'b0100, 4'b0100, 4'b0100, 4'b1000, 4'b0001};

        reset   = 1'b1;
        hready  = 1'b1;
        hreq    = 4'b0000;
        hlock   = 4'b0000;
        weights = {4'd0, 4'd3, 4'd1, 4'd1};
        set_xfer(IDLE, SINGLE);

        // Park after reset
        for (int i = 0; i < 2; i++) begin
            step();
            chk("reset_granted", gnt_m[1], 4'b0001);
            chk("reset_grantedD", gntd_m[1], 4'b0001);
        end
        reset = 1'b0;
        for (int i = 0; i < 10; i++) begin
            step();
            chk("park_granted", gnt_m[1], 4'b0001);
            chk("park_grantedD", gntd_m[2], 4'b0001);
        end

        // Rotation (mode 1) and weighted quota (mode 2), all SINGLE NONSEQ
        hreq = 4'b1111;
        set_xfer(NONSEQ, SINGLE);
        prev_rr = 4'b0001;
        for (int i = 0; i < 12; i++) begin
            step();
            chk("rr_rotation", gnt_m[1], exp_rr[i % 4]);
            chk("rr_dataphase_lag", gntd_m[1], prev_rr);
            chk("wrr_quota", gnt_m[2], exp_wrr[i % 6]);
            chk("fixed_prio", gnt_m[0], 4'b0001);
            prev_rr = exp_rr[i % 4];
        end

        // INCR8 burst by M1 with a 3-cycle wait mid-burst while M2 requests
        do_reset();
        hreq = 4'b0010;
        step();
        chk("burst_m1_granted", gnt_m[1], 4'b0010);
        hreq = 4'b0110;
        set_xfer(NONSEQ, INCR8);
        step();
        chk("burst_nonseq_hold", gnt_m[1], 4'b0010);
        set_xfer(SEQ, INCR8);
        for (int i = 0; i < 3; i++) begin
            step();
            chk("burst_seq_hold", gnt_m[1], 4'b0010);
        end
        hready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            chk("burst_wait_hold", gnt_m[2], 4'b0010);
            chk("burst_wait_dataphase", gntd_m[1], 4'b0010);
        end
        hready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            step();
            chk("burst_end_rr", gnt_m[1], (i == 3) ? 4'b0100 : 4'b0010);
        end
        chk("burst_end_wrr", gnt_m[2], 4'b0100);
        chk("burst_end_fixed", gnt_m[0], 4'b0010);
        set_xfer(IDLE, SINGLE);

        // Locked sequence by M3 while M0 requests
        do_reset();
        hreq  = 4'b1000;
        hlock = 4'b1000;
        step();
        chk("lock_m3_granted", gnt_m[0], 4'b1000);
        hreq = 4'b1001;
        set_xfer(NONSEQ, SINGLE);
        for (int i = 0; i < 5; i++) begin
            step();
            chk("lock_hold_fixed", gnt_m[0], 4'b1000);
            chk("lock_hold_rr", gnt_m[1], 4'b1000);
            chk("lock_hmastlock", {3'b000, ml_m[1]}, 4'b0001);
        end
        hlock = 4'b0000;
        set_xfer(IDLE, SINGLE);
        step();
        chk("unlock_rr", gnt_m[1], 4'b0001);
        chk("unlock_wrr", gnt_m[2], 4'b0001);
        chk("unlock_hmastlock", {3'b000, ml_m[1]}, 4'b0000);

        // Reset during beat 3 of an INCR16 by M2
        do_reset();
        hreq = 4'b0100;
        step();
        chk("rst_burst_m2", gnt_m[1], 4'b0100);
        hreq = 4'b0101;
        set_xfer(NONSEQ, INCR16);
        step();
        set_xfer(SEQ, INCR16);
        step();
        reset = 1'b1;
        step();
        chk("midburst_rst_granted", gnt_m[1], 4'b0001);
        chk("midburst_rst_grantedD", gntd_m[1], 4'b0001);
        chk("midburst_rst_mlock", {3'b000, ml_m[1]}, 4'b0000);
        reset = 1'b0;
        set_xfer(IDLE, SINGLE);
        step();
        chk("midburst_rst_rearb", gnt_m[1], 4'b0100);

        // Deterministic mixed sweep, checked by the model only
        do_reset();
        for (int k = 0; k < 80; k++) begin
            hreq   = 4'((k * 7 + 3) % 16);
            hlock  = (k % 13 < 4) ? 4'b0110 : 4'b0000;
            hready = (k % 6 != 5);
            set_xfer(2'((k * 3) % 4), 3'(k % 8));
            step();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule : tb_ahb_arbiter_wrr
`default_nettype wire
